aq_djpeg_mcu_tracker: RTL and testbench
=======================================

# aq_djpeg_mcu_tracker

Parametrised MCU/block position tracker for the JPEG decoder, succeeding the fixed 12-bit block X/Y counter in the Huffman top level. It tracks the expected component and luma sub-block within each MCU for 1–3 component images with programmable luma sampling, and advances the MCU X/Y position. It supports a restart interval with an ack handshake, and flags frame completion and sequencing errors. It sits between the Huffman decoder's per-block completion pulse and the decoder's input gating and DC-predictor control.

## Interface
- CW, 12, width of MCU coordinate and MCU dimension buses
- RW, 16, width of restart interval and restart MCU counter
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ProcessInit  in  1  frame start; clears all state, same effect as rst
- JpegComp  in  3  component count; 1..3 valid, 0 treated as 1, 4..7 treated as 3
- SubSamplingW  in  2  luma horizontal blocks per MCU (H); 0→1, 3→2
- SubSamplingH  in  2  luma vertical blocks per MCU (V); 0→1, 3→2
- McuWidth  in  CW  MCUs per row; 0 treated as 1
- McuHeight  in  CW  MCU rows; 0 treated as 1
- RestartInterval  in  RW  MCUs between restart markers; 0 = disabled
- BlockDone  in  1  one-cycle pulse: one 8x8 block fully decoded
- RestartAck  in  1  restart marker consumed
- BlockColor  out  3  component of the next expected block (0 Y, 1 Cb, 2 Cr)
- BlockIndex  out  2  luma sub-block index within the MCU, raster order; 0 for chroma
- McuX  out  CW  current MCU column
- McuY  out  CW  current MCU row
- McuDone  out  1  one-cycle pulse: last block of an MCU accepted
- RestartExpect  out  1  level: restart marker due; BlockDone not accepted
- Finish  out  1  sticky: last MCU of frame complete
- Error  out  1  sticky: BlockDone arrived while not accepting

## Operation
- Config inputs are sampled every cycle. They must be stable from ProcessInit until Finish.
- MCU block sequence:
  - JpegComp==1: one luma block per MCU; H and V are ignored (non-interleaved).
  - Otherwise: H*V luma blocks (BlockIndex 0..H*V-1), then one block of component 1, then (if 3 components) one block of component 2.
- State machine:
  - States are RUN, WAIT_RST and DONE.
  - rst or ProcessInit: → RUN. All counters/outputs are 0; Error and Finish are cleared.
  - RUN, BlockDone, not last block of MCU: advance to the next BlockColor/BlockIndex.
  - RUN, BlockDone, last block of MCU: pulse McuDone and reset BlockColor/BlockIndex to 0. Then:
    - Last MCU (McuX==McuWidth-1 and McuY==McuHeight-1): → DONE with Finish=1. McuX/McuY hold their final values.
    - Else if McuX==McuWidth-1: McuX→0, McuY+1. Otherwise McuX+1.
    - Restart counter +1 (not on the last MCU). If RestartInterval≠0 and the counter equals RestartInterval: → WAIT_RST, RestartExpect=1, counter→0.
  - WAIT_RST, RestartAck: → RUN, RestartExpect=0.
  - WAIT_RST, BlockDone (without ack): ignored; Error=1.
  - DONE, BlockDone: ignored; Error=1. Finish holds until rst/ProcessInit.
  - RestartAck outside WAIT_RST is ignored.
- Simultaneous events:
  - rst/ProcessInit beats everything.
  - RestartAck and BlockDone in the same WAIT_RST cycle: ack is taken, the block is ignored, Error=1.
- Arithmetic:
  - All comparisons use full CW/RW widths.
  - Coordinates never exceed dimension-1, so no wrap-around is possible.
  - The restart counter saturates at the interval.

## Timing
- Reset values: BlockColor=0, BlockIndex=0, McuX=0, McuY=0, McuDone=0, RestartExpect=0, Finish=0, Error=0.
- All outputs are registered. BlockDone in cycle n is reflected in every output at cycle n+1.
- McuDone is high exactly one cycle (n+1).
- RestartExpect rises in the same cycle as the corresponding McuDone.
- RestartExpect falls the cycle after RestartAck.
- BlockDone is accepted back-to-back in RUN, every cycle; there is no internal stall.
- rst asserted mid-frame: outputs are at reset values on the next edge regardless of state.

## Test plan
- 4:2:0: JpegComp=3, H=V=2, McuWidth=2, McuHeight=1, 12 BlockDone pulses:
  - BlockColor sequence is 0,0,0,0,1,2 repeated.
  - BlockIndex sequence is 0,1,2,3,0,0.
  - McuDone after pulses 6 and 12; McuX goes 0→1.
  - Finish=1 after pulse 12.
- Gray: JpegComp=1, McuWidth=3, McuHeight=2, 6 pulses:
  - McuX goes 0,1,2,0,1,2; McuY goes 0→1 after pulse 3.
  - Finish after pulse 6.
  - A 7th pulse sets Error=1 and leaves McuX=2, McuY=1 unchanged.
- Restart: JpegComp=1, McuWidth=4, McuHeight=1, RestartInterval=2:
  - RestartExpect=1 after pulse 2.
  - A pulse while expecting sets Error=1 and does not change McuX=2.
  - RestartAck clears RestartExpect.
  - After pulse 4, Finish=1 and RestartExpect stays 0.
- Init collision: ProcessInit and BlockDone in the same cycle mid-MCU (BlockColor=1, Error=1) → all outputs 0 next cycle.
- Reset mid-frame: rst=1 while in WAIT_RST → all outputs at reset values next edge; a following BlockDone yields BlockIndex=1 (H=2,V=1,JpegComp=3).
- Degenerate config: McuWidth=0, McuHeight=0, JpegComp=0 → one pulse gives McuDone=1 and Finish=1.

Source files
------------

// File: rtl/aq_djpeg_mcu_tracker.sv
// aq_djpeg_mcu_tracker
// Tracks the expected component / luma sub-block inside each MCU, the MCU
// X/Y position, restart-interval handshakes, frame completion and
// sequencing errors for the JPEG decoder's Huffman front end.
// Every output is a plain register; BlockDone in cycle n shows up at n+1.
module aq_djpeg_mcu_tracker #(
   parameter int CW = 12,
   parameter int RW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ProcessInit,
   input  logic [2:0]    JpegComp,
   input  logic [1:0]    SubSamplingW,
   input  logic [1:0]    SubSamplingH,
   input  logic [CW-1:0] McuWidth,
   input  logic [CW-1:0] McuHeight,
   input  logic [RW-1:0] RestartInterval,
   input  logic          BlockDone,
   input  logic          RestartAck,
   output logic [2:0]    BlockColor,
   output logic [1:0]    BlockIndex,
   output logic [CW-1:0] McuX,
   output logic [CW-1:0] McuY,
   output logic          McuDone,
   output logic          RestartExpect,
   output logic          Finish,
   output logic          Error
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_WAIT_RST = 2'd1,
      S_DONE     = 2'd2
   } state_t;

   // Registered state
   state_t        r_state;
   logic [2:0]    r_color;
   logic [1:0]    r_index;
   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic [RW-1:0] r_rst_cnt;
   logic          r_mcu_done;
   logic          r_restart_expect;
   logic          r_finish;
   logic          r_error;

   // Next-state values
   state_t        w_state_nxt;
   logic [2:0]    w_color_nxt;
   logic [1:0]    w_index_nxt;
   logic [CW-1:0] w_x_nxt;
   logic [CW-1:0] w_y_nxt;
   logic [RW-1:0] w_rst_cnt_nxt;
   logic          w_mcu_done_nxt;
   logic          w_error_nxt;

   // Normalised configuration
   logic [1:0]    w_comp;
   logic          w_h2;
   logic          w_v2;
   logic [1:0]    w_luma_last;
   logic [CW-1:0] w_x_last;
   logic [CW-1:0] w_y_last;
   logic          w_last_blk;
   logic          w_last_mcu;
   logic [RW-1:0] w_cnt_inc;

   // Clamp the configuration into its legal ranges (0 -> 1, overflow -> max)
   always_comb begin
      unique case (JpegComp)
         3'd0, 3'd1: w_comp = 2'd1;
         3'd2:       w_comp = 2'd2;
         default:    w_comp = 2'd3;
      endcase
      // Sampling factor 2 or 3 both mean two blocks; 0 or 1 mean one.
      w_h2        = (SubSamplingW >= 2'd2);
      w_v2        = (SubSamplingH >= 2'd2);
      // H*V-1 for H,V in {1,2}: 1x1 -> 0, 2x1/1x2 -> 1, 2x2 -> 3
      w_luma_last = {w_h2 & w_v2, w_h2 | w_v2};
      w_x_last    = (McuWidth  == '0) ? '0 : McuWidth  - CW'(1);
      w_y_last    = (McuHeight == '0) ? '0 : McuHeight - CW'(1);
      w_last_mcu  = (r_x == w_x_last) && (r_y == w_y_last);
      w_cnt_inc   = r_rst_cnt + RW'(1);
      // The final block of an MCU is the highest component present;
      // a single-component image is non-interleaved, so each luma block ends an MCU.
      w_last_blk  = ((r_color == 3'd0) && (w_comp == 2'd1)) ||
                    ((r_color == 3'd1) && (w_comp == 2'd2)) ||
                    (r_color == 3'd2);
   end

   // Next-state and next-output logic for the RUN / WAIT_RST / DONE machine
   always_comb begin
      // NOTE: every signal gets a default first so no path can leave it
      // unassigned, which would otherwise infer a latch.
      w_state_nxt    = r_state;
      w_color_nxt    = r_color;
      w_index_nxt    = r_index;
      w_x_nxt        = r_x;
      w_y_nxt        = r_y;
      w_rst_cnt_nxt  = r_rst_cnt;
      w_mcu_done_nxt = 1'b0;
      w_error_nxt    = r_error;

      unique case (r_state)
         S_RUN: begin
            if (BlockDone) begin
               if (!w_last_blk) begin
                  if (r_color == 3'd0) begin
                     if (r_index == w_luma_last) begin
                        w_color_nxt = 3'd1;
                        w_index_nxt = 2'd0;
                     end else begin
                        w_index_nxt = r_index + 2'd1;
                     end
                  end else begin
                     w_color_nxt = r_color + 3'd1;
                  end
               end else begin
                  w_mcu_done_nxt = 1'b1;
                  w_color_nxt    = 3'd0;
                  w_index_nxt    = 2'd0;
                  if (w_last_mcu) begin
                     // Coordinates hold their final values in DONE.
                     w_state_nxt = S_DONE;
                  end else begin
                     if (r_x == w_x_last) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + CW'(1);
                     end else begin
                        w_x_nxt = r_x + CW'(1);
                     end
                     // Counting only while an interval is set keeps the
                     // counter saturated at the interval value.
                     if (RestartInterval != '0) begin
                        if (w_cnt_inc >= RestartInterval) begin
                           w_rst_cnt_nxt = '0;
                           w_state_nxt   = S_WAIT_RST;
                        end else begin
                           w_rst_cnt_nxt = w_cnt_inc;
                        end
                     end
                  end
               end
            end
         end

         S_WAIT_RST: begin
            // A block here is out of sequence even when the ack arrives with it.
            if (BlockDone)  w_error_nxt = 1'b1;
            if (RestartAck) w_state_nxt = S_RUN;
         end

         S_DONE: begin
            if (BlockDone) w_error_nxt = 1'b1;
         end

         default: w_state_nxt = S_RUN;
      endcase
   end

   // State and output registers; rst and ProcessInit both restart the frame
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst || ProcessInit) begin
         r_state          <= S_RUN;
         r_color          <= 3'd0;
         r_index          <= 2'd0;
         r_x              <= '0;
         r_y              <= '0;
         r_rst_cnt        <= '0;
         r_mcu_done       <= 1'b0;
         r_restart_expect <= 1'b0;
         r_finish         <= 1'b0;
         r_error          <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_color          <= w_color_nxt;
         r_index          <= w_index_nxt;
         r_x              <= w_x_nxt;
         r_y              <= w_y_nxt;
         r_rst_cnt        <= w_rst_cnt_nxt;
         r_mcu_done       <= w_mcu_done_nxt;
         r_restart_expect <= (w_state_nxt == S_WAIT_RST);
         r_finish         <= (w_state_nxt == S_DONE);
         r_error          <= w_error_nxt;
      end
   end

   assign BlockColor    = r_color;
   assign BlockIndex    = r_index;
   assign McuX          = r_x;
   assign McuY          = r_y;
   assign McuDone       = r_mcu_done;
   assign RestartExpect = r_restart_expect;
   assign Finish        = r_finish;
   assign Error         = r_error;

endmodule

// File: tb/tb_aq_djpeg_mcu_tracker.sv
// Directed bench for aq_djpeg_mcu_tracker: 4:2:0 sequencing, grayscale
// raster, restart handshake, init/reset collisions and degenerate config.
module tb_aq_djpeg_mcu_tracker;

   localparam int CW = 12;
   localparam int RW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ProcessInit = 1'b0;
   logic [2:0]    JpegComp = 3'd1;
   logic [1:0]    SubSamplingW = 2'd1;
   logic [1:0]    SubSamplingH = 2'd1;
   logic [CW-1:0] McuWidth = CW'(1);
   logic [CW-1:0] McuHeight = CW'(1);
   logic [RW-1:0] RestartInterval = '0;
   logic          BlockDone = 1'b0;
   logic          RestartAck = 1'b0;
   logic [2:0]    BlockColor;
   logic [1:0]    BlockIndex;
   logic [CW-1:0] McuX;
   logic [CW-1:0] McuY;
   logic          McuDone;
   logic          RestartExpect;
   logic          Finish;
   logic          Error;

   int n_checks = 0;
   int n_errors = 0;

   int exp_col[6] = '{0, 0, 0, 0, 1, 2};
   int exp_idx[6] = '{0, 1, 2, 3, 0, 0};

   aq_djpeg_mcu_tracker #(.CW(CW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
      .JpegComp(JpegComp), .SubSamplingW(SubSamplingW), .SubSamplingH(SubSamplingH),
      .McuWidth(McuWidth), .McuHeight(McuHeight), .RestartInterval(RestartInterval),
      .BlockDone(BlockDone), .RestartAck(RestartAck),
      .BlockColor(BlockColor), .BlockIndex(BlockIndex), .McuX(McuX), .McuY(McuY),
      .McuDone(McuDone), .RestartExpect(RestartExpect), .Finish(Finish), .Error(Error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the falling edge.
   task automatic pulse();
      @(negedge clk) BlockDone = 1'b1;
      @(negedge clk) BlockDone = 1'b0;
   endtask

   task automatic ack();
      @(negedge clk) RestartAck = 1'b1;
      @(negedge clk) RestartAck = 1'b0;
   endtask

   task automatic init();
      @(negedge clk) ProcessInit = 1'b1;
      @(negedge clk) ProcessInit = 1'b0;
   endtask

   task automatic cfg(input logic [2:0] c, input logic [1:0] sw, input logic [1:0] sh,
                      input int w, input int h, input int ri);
      JpegComp = c; SubSamplingW = sw; SubSamplingH = sh;
      McuWidth = CW'(w); McuHeight = CW'(h); RestartInterval = RW'(ri);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_col"},  32'(BlockColor), 0);
      check({tag, "_idx"},  32'(BlockIndex), 0);
      check({tag, "_x"},    32'(McuX), 0);
      check({tag, "_y"},    32'(McuY), 0);
      check({tag, "_mdone"}, 32'(McuDone), 0);
      check({tag, "_rexp"}, 32'(RestartExpect), 0);
      check({tag, "_fin"},  32'(Finish), 0);
      check({tag, "_err"},  32'(Error), 0);
   endtask

   initial begin
      // Reset values
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      check_zero("reset");

      // 4:2:0, two MCUs in one row
      cfg(3'd3, 2'd2, 2'd2, 2, 1, 0);
      init();
      for (int k = 1; k <= 12; k++) begin
         pulse();
         check($sformatf("420_col_%0d", k), 32'(BlockColor), 32'(exp_col[k % 6]));
         check($sformatf("420_idx_%0d", k), 32'(BlockIndex), 32'(exp_idx[k % 6]));
         check($sformatf("420_mdone_%0d", k), 32'(McuDone), 32'((k % 6) == 0));
         check($sformatf("420_x_%0d", k), 32'(McuX), (k >= 6) ? 1 : 0);
         check($sformatf("420_fin_%0d", k), 32'(Finish), 32'(k == 12));
      end

      // Grayscale 3x2 raster, then an extra block after the frame
      cfg(3'd1, 2'd2, 2'd2, 3, 2, 0);
      init();
      check_zero("gray_init");
      for (int k = 1; k <= 6; k++) begin
         pulse();
         check($sformatf("gray_x_%0d", k), 32'(McuX), (k < 6) ? (k % 3) : 2);
         check($sformatf("gray_y_%0d", k), 32'(McuY), (k < 6) ? (k / 3) : 1);
         check($sformatf("gray_col_%0d", k), 32'(BlockColor), 0);
         check($sformatf("gray_mdone_%0d", k), 32'(McuDone), 1);
         check($sformatf("gray_fin_%0d", k), 32'(Finish), 32'(k == 6));
      end
      pulse();
      check("gray_extra_err", 32'(Error), 1);
      check("gray_extra_x", 32'(McuX), 2);
      check("gray_extra_y", 32'(McuY), 1);
      check("gray_extra_mdone", 32'(McuDone), 0);
      check("gray_extra_fin", 32'(Finish), 1);

      // Restart interval 2 over a 4x1 grayscale frame
      cfg(3'd1, 2'd0, 2'd0, 4, 1, 2);
      init();
      pulse();
      check("rst_p1_x", 32'(McuX), 1);
      check("rst_p1_rexp", 32'(RestartExpect), 0);
      pulse();
      check("rst_p2_x", 32'(McuX), 2);
      check("rst_p2_rexp", 32'(RestartExpect), 1);
      check("rst_p2_mdone", 32'(McuDone), 1);
      pulse();
      check("rst_blocked_err", 32'(Error), 1);
      check("rst_blocked_x", 32'(McuX), 2);
      check("rst_blocked_rexp", 32'(RestartExpect), 1);
      check("rst_blocked_mdone", 32'(McuDone), 0);
      ack();
      check("rst_ack_rexp", 32'(RestartExpect), 0);
      pulse();
      check("rst_p3_x", 32'(McuX), 3);
      pulse();
      check("rst_p4_fin", 32'(Finish), 1);
      check("rst_p4_rexp", 32'(RestartExpect), 0);
      check("rst_p4_x", 32'(McuX), 3);

      // ProcessInit colliding with BlockDone mid-MCU while Error is set
      cfg(3'd3, 2'd0, 2'd0, 2, 1, 1);
      init();
      pulse(); pulse(); pulse();
      check("coll_rexp", 32'(RestartExpect), 1);
      check("coll_x", 32'(McuX), 1);
      pulse();
      ack();
      pulse();
      check("coll_pre_col", 32'(BlockColor), 1);
      check("coll_pre_err", 32'(Error), 1);
      @(negedge clk) begin ProcessInit = 1'b1; BlockDone = 1'b1; end
      @(negedge clk) begin ProcessInit = 1'b0; BlockDone = 1'b0; end
      check_zero("coll_post");

      // Synchronous reset while waiting for a restart marker
      cfg(3'd3, 2'd2, 2'd1, 2, 1, 1);
      init();
      pulse(); pulse(); pulse(); pulse();
      check("mid_rexp", 32'(RestartExpect), 1);
      check("mid_mdone", 32'(McuDone), 1);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check_zero("mid_rst");
      pulse();
      check("mid_after_idx", 32'(BlockIndex), 1);
      check("mid_after_col", 32'(BlockColor), 0);

      // Degenerate configuration: zero dimensions and zero components
      cfg(3'd0, 2'd0, 2'd0, 0, 0, 0);
      init();
      pulse();
      check("degen_mdone", 32'(McuDone), 1);
      check("degen_fin", 32'(Finish), 1);
      check("degen_x", 32'(McuX), 0);
      check("degen_y", 32'(McuY), 0);
      check("degen_err", 32'(Error), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
